branch_resolve_unit: RTL and testbench

- Resolution side of the branch prediction loop: carries each decode-stage prediction down the pipeline, checks it against the actual outcome in M, and drives fetch redirect, wrong-path flush and the predictor update stream.
- Sits between decode, the hazard unit and the predictor's update port (`branchM`/`pcM`/`actual_takeM`).
- Also keeps saturating branch and mispredict counters for performance reporting.

---
 rtl/branch_resolve_unit_if.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 147 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// ============================================================================
// branch_resolve_unit_if
// Decode / hazard / M-stage signal bundle for the branch resolve unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  logic             stallF;
  logic             stallE;
  logic             flushE;
  logic             flushM;
  logic             branchD;
  logic             pred_takeD;
  logic [31:0]      pcD;
  logic [31:0]      targetD;
  logic             actual_takeM;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush_req;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic             mispredictM;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output stallF, stallE, flushE, flushM, branchD, pred_takeD, pcD, targetD, actual_takeM,
    input  redirect_valid, redirect_pc, flush_req, upd_valid, upd_pc, upd_taken,
           mispredictM, branch_cnt, mispred_cnt
  );

  modport slave (
    input  stallF, stallE, flushE, flushM, branchD, pred_takeD, pcD, targetD, actual_takeM,
    output redirect_valid, redirect_pc, flush_req, upd_valid, upd_pc, upd_taken,
           mispredictM, branch_cnt, mispred_cnt
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit
// Carries D-stage predictions to M, resolves them, redirects fetch and feeds
// the predictor update port; keeps saturating branch/mispredict counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
  parameter int CNT_W = 32  // must match the CNT_W of the connected interface
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_resolve_unit_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [31:0]      r_holdPc;

  logic             r_vE;
  logic             r_consumedE;
  logic             r_predE;
  logic [31:0]      r_pcE;
  logic [31:0]      r_targetE;
  logic [31:0]      r_fallE;

  logic             r_vM;
  logic             r_predM;
  logic [31:0]      r_pcM;
  logic [31:0]      r_targetM;
  logic [31:0]      r_fallM;

  logic [CNT_W-1:0] r_branchCnt;
  logic [CNT_W-1:0] r_mispredCnt;

  logic             w_mispredict;
  logic [31:0]      w_correctPc;
  logic             w_redirect;

  always_comb begin
    w_mispredict = r_vM & (r_predM != bus.actual_takeM);
    w_correctPc  = bus.actual_takeM ? r_targetM : r_fallM;
    w_redirect   = (r_state == S_HOLD) | w_mispredict;
  end

  assign bus.redirect_valid = w_redirect;
  assign bus.redirect_pc    = (r_state == S_HOLD) ? r_holdPc :
                              (w_mispredict ? w_correctPc : 32'd0);
  assign bus.flush_req      = w_redirect;
  assign bus.upd_valid      = r_vM;
  assign bus.upd_pc         = r_vM ? r_pcM : 32'd0;
  assign bus.upd_taken      = r_vM & bus.actual_takeM;
  assign bus.mispredictM    = w_mispredict;
  assign bus.branch_cnt     = r_branchCnt;
  assign bus.mispred_cnt    = r_mispredCnt;

  // D->E register; a stalled entry is handed to M only once (consumed flag)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vE        <= 1'b0;
      r_consumedE <= 1'b0;
      r_predE     <= 1'b0;
      r_pcE       <= 32'd0;
      r_targetE   <= 32'd0;
      r_fallE     <= 32'd0;
    end else begin
      if (!bus.stallE) begin
        r_predE   <= bus.pred_takeD;
        r_pcE     <= bus.pcD;
        r_targetE <= bus.targetD;
        r_fallE   <= bus.pcD + 32'd4;
      end
      if (bus.flushE || w_redirect) begin
        r_vE        <= 1'b0;
        r_consumedE <= 1'b0;
      end else if (!bus.stallE) begin
        r_vE        <= bus.branchD;
        r_consumedE <= 1'b0;
      end else begin
        r_consumedE <= 1'b1;
      end
    end
  end

  // E->M register; everything behind a redirect is wrong path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vM      <= 1'b0;
      r_predM   <= 1'b0;
      r_pcM     <= 32'd0;
      r_targetM <= 32'd0;
      r_fallM   <= 32'd0;
    end else begin
      r_vM      <= r_vE & ~r_consumedE & ~bus.flushM & ~w_redirect;
      r_predM   <= r_predE;
      r_pcM     <= r_pcE;
      r_targetM <= r_targetE;
      r_fallM   <= r_fallE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_holdPc <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mispredict && bus.stallF) begin
            r_state  <= S_HOLD;
            r_holdPc <= w_correctPc;
          end
        end
        S_HOLD: begin
          if (!bus.stallF) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branchCnt  <= '0;
      r_mispredCnt <= '0;
    end else begin
      if (r_vM && !(&r_branchCnt)) begin
        r_branchCnt <= r_branchCnt + c_ONE;
      end
      if (w_mispredict && !(&r_mispredCnt)) begin
        r_mispredCnt <= r_mispredCnt + c_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// tb_branch_resolve_unit
// Directed self-checking bench for branch_resolve_unit (CNT_W = 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_branch(input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
    bus.branchD    = 1'b1;
    bus.pred_takeD = pred;
    bus.pcD        = pc;
    bus.targetD    = tgt;
    tick();
    bus.branchD    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++; if (bus.redirect_valid !== 1'b0) begin fails++; $display("FAIL reset_redirect_valid got %b expected 0", bus.redirect_valid); end
    tests++; if (bus.redirect_pc !== 32'd0) begin fails++; $display("FAIL reset_redirect_pc got %h expected 0", bus.redirect_pc); end
    tests++; if (bus.upd_valid !== 1'b0 || bus.flush_req !== 1'b0) begin fails++; $display("FAIL reset_upd_flush got %b%b expected 00", bus.upd_valid, bus.flush_req); end
    tests++; if (bus.branch_cnt !== 4'h0 || bus.mispred_cnt !== 4'h0) begin fails++; $display("FAIL reset_counters got %h/%h expected 0/0", bus.branch_cnt, bus.mispred_cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_correct_taken();
    send_branch(1'b1, 32'h100, 32'h200);
    bus.actual_takeM = 1'b1;
    #1;
    tests++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h100 || bus.upd_taken !== 1'b1) begin fails++; $display("FAIL taken_update got v=%b pc=%h t=%b expected v=1 pc=100 t=1", bus.upd_valid, bus.upd_pc, bus.upd_taken); end
    tests++; if (bus.mispredictM !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.flush_req !== 1'b0) begin fails++; $display("FAIL taken_no_redirect got mp=%b rv=%b fr=%b expected 000", bus.mispredictM, bus.redirect_valid, bus.flush_req); end
    tick();
    tests++; if (bus.branch_cnt !== 4'd1 || bus.mispred_cnt !== 4'd0) begin fails++; $display("FAIL taken_counters got %0d/%0d expected 1/0", bus.branch_cnt, bus.mispred_cnt); end
    tests++; if (bus.upd_valid !== 1'b0) begin fails++; $display("FAIL taken_single_update got %b expected 0", bus.upd_valid); end
  endtask

  task automatic test_mispredict_nt();
    bus.branchD = 1'b1; bus.pred_takeD = 1'b1; bus.pcD = 32'h100; bus.targetD = 32'h200;
    tick();
    // A younger branch follows directly and must be squashed by the redirect.
    bus.pcD = 32'h180; bus.targetD = 32'h280;
    tick();
    bus.branchD = 1'b0;
    bus.actual_takeM = 1'b0;
    #1;
    tests++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h104) begin fails++; $display("FAIL nt_redirect got rv=%b pc=%h expected rv=1 pc=104", bus.redirect_valid, bus.redirect_pc); end
    tests++; if (bus.flush_req !== 1'b1 || bus.mispredictM !== 1'b1) begin fails++; $display("FAIL nt_flush got fr=%b mp=%b expected 11", bus.flush_req, bus.mispredictM); end
    tests++; if (bus.upd_valid !== 1'b1 || bus.upd_taken !== 1'b0) begin fails++; $display("FAIL nt_update got v=%b t=%b expected v=1 t=0", bus.upd_valid, bus.upd_taken); end
    tick();
    bus.actual_takeM = 1'b1;
    #1;
    tests++; if (bus.upd_valid !== 1'b0 || bus.redirect_valid !== 1'b0) begin fails++; $display("FAIL nt_squash got v=%b rv=%b expected 00", bus.upd_valid, bus.redirect_valid); end
    tests++; if (bus.branch_cnt !== 4'd2 || bus.mispred_cnt !== 4'd1) begin fails++; $display("FAIL nt_counters got %0d/%0d expected 2/1", bus.branch_cnt, bus.mispred_cnt); end
    tick();
  endtask

  task automatic test_mispredict_stallf();
    send_branch(1'b0, 32'h300, 32'h400);
    bus.actual_takeM = 1'b1;
    bus.stallF = 1'b1;
    #1;
    tests++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h400) begin fails++; $display("FAIL hold_first got rv=%b pc=%h expected rv=1 pc=400", bus.redirect_valid, bus.redirect_pc); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      bus.actual_takeM = 1'b0;
      bus.stallF = (i < 3);
      #1;
      tests++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h400 || bus.flush_req !== 1'b1) begin fails++; $display("FAIL hold_cycle%0d got rv=%b pc=%h fr=%b expected rv=1 pc=400 fr=1", i, bus.redirect_valid, bus.redirect_pc, bus.flush_req); end
      tests++; if (bus.upd_valid !== 1'b0 || bus.mispredictM !== 1'b0) begin fails++; $display("FAIL hold_quiet%0d got v=%b mp=%b expected 00", i, bus.upd_valid, bus.mispredictM); end
    end
    tick();
    tests++; if (bus.redirect_valid !== 1'b0 || bus.flush_req !== 1'b0) begin fails++; $display("FAIL hold_release got rv=%b fr=%b expected 00", bus.redirect_valid, bus.flush_req); end
    tests++; if (bus.branch_cnt !== 4'd3 || bus.mispred_cnt !== 4'd2) begin fails++; $display("FAIL hold_counters got %0d/%0d expected 3/2", bus.branch_cnt, bus.mispred_cnt); end
  endtask

  task automatic test_wrap_flushm();
    send_branch(1'b1, 32'hFFFF_FFFC, 32'h10);
    bus.actual_takeM = 1'b0;
    bus.flushM = 1'b1;
    #1;
    tests++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0 || bus.mispredictM !== 1'b1) begin fails++; $display("FAIL wrap_redirect got rv=%b pc=%h mp=%b expected rv=1 pc=0 mp=1", bus.redirect_valid, bus.redirect_pc, bus.mispredictM); end
    tick();
    bus.flushM = 1'b0;
    #1;
    tests++; if (bus.mispred_cnt !== 4'd3 || bus.branch_cnt !== 4'd4) begin fails++; $display("FAIL wrap_counters got %0d/%0d expected 4/3", bus.branch_cnt, bus.mispred_cnt); end
  endtask

  task automatic test_flush_stall();
    bus.branchD = 1'b1; bus.pred_takeD = 1'b1; bus.pcD = 32'h440; bus.targetD = 32'h480;
    bus.flushE = 1'b1;
    tick();
    bus.branchD = 1'b0; bus.flushE = 1'b0;
    bus.actual_takeM = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (bus.upd_valid !== 1'b0) begin fails++; $display("FAIL flushE_no_update%0d got %b expected 0", i, bus.upd_valid); end
    end
    bus.branchD = 1'b1; bus.pred_takeD = 1'b1; bus.pcD = 32'h500; bus.targetD = 32'h600;
    tick();
    bus.branchD = 1'b0;
    bus.stallE = 1'b1;
    tick();
    tests++; if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h500) begin fails++; $display("FAIL stallE_first got v=%b pc=%h expected v=1 pc=500", bus.upd_valid, bus.upd_pc); end
    tick();
    tests++; if (bus.upd_valid !== 1'b0) begin fails++; $display("FAIL stallE_dup1 got %b expected 0", bus.upd_valid); end
    tick();
    bus.stallE = 1'b0;
    #1;
    tests++; if (bus.upd_valid !== 1'b0) begin fails++; $display("FAIL stallE_dup2 got %b expected 0", bus.upd_valid); end
    tick();
    tests++; if (bus.upd_valid !== 1'b0) begin fails++; $display("FAIL stallE_dup3 got %b expected 0", bus.upd_valid); end
    tests++; if (bus.branch_cnt !== 4'd5 || bus.mispred_cnt !== 4'd3) begin fails++; $display("FAIL stallE_counters got %0d/%0d expected 5/3", bus.branch_cnt, bus.mispred_cnt); end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_branch(1'b1, 32'h1000 + 32'(i * 16), 32'h2000);
      bus.actual_takeM = 1'b0;
      tick();
    end
    tests++; if (bus.branch_cnt !== 4'hF || bus.mispred_cnt !== 4'hF) begin fails++; $display("FAIL saturation got %h/%h expected F/F", bus.branch_cnt, bus.mispred_cnt); end
  endtask

  task automatic test_async_reset();
    send_branch(1'b0, 32'h700, 32'h800);
    bus.actual_takeM = 1'b1;
    bus.stallF = 1'b1;
    tick();
    #1;
    tests++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h800) begin fails++; $display("FAIL areset_in_hold got rv=%b pc=%h expected rv=1 pc=800", bus.redirect_valid, bus.redirect_pc); end
    #1;
    rst = 1'b1;
    #1;
    tests++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 32'h0 || bus.flush_req !== 1'b0) begin fails++; $display("FAIL areset_redirect got rv=%b pc=%h fr=%b expected 0/0/0", bus.redirect_valid, bus.redirect_pc, bus.flush_req); end
    tests++; if (bus.branch_cnt !== 4'h0 || bus.mispred_cnt !== 4'h0 || bus.upd_valid !== 1'b0) begin fails++; $display("FAIL areset_state got %h/%h v=%b expected 0/0 v=0", bus.branch_cnt, bus.mispred_cnt, bus.upd_valid); end
    @(negedge clk);
    rst = 1'b0;
    bus.stallF = 1'b0;
    tick();
    tests++; if (bus.redirect_valid !== 1'b0) begin fails++; $display("FAIL areset_after got %b expected 0", bus.redirect_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.stallF = 1'b0; bus.stallE = 1'b0; bus.flushE = 1'b0; bus.flushM = 1'b0;
    bus.branchD = 1'b0; bus.pred_takeD = 1'b0; bus.pcD = 32'd0; bus.targetD = 32'd0;
    bus.actual_takeM = 1'b0;
    @(negedge clk);
    test_reset();
    test_correct_taken();
    test_mispredict_nt();
    test_mispredict_stallf();
    test_wrap_flushm();
    test_flush_stall();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
